// File: rtl/mem_ctrl_arbiter.sv
// -----------------------------------------------------------------------------
// mem_ctrl_arbiter
//
// Arbitrates icache block reads and dcache block reads/writebacks onto a
// single main-memory request port. At most one transaction is in flight.
//
// The icache normally has priority. A starvation counter tracks consecutive
// icache grants that were made while the dcache was also waiting. When the
// counter reaches STARVE_LIMIT, the dcache wins the next contested grant.
//
// A pipeline flush during an outstanding dcache transaction sets a squash
// flag. The memory transaction still runs to completion, but the dcache never
// sees the response.
//
// Ports
//   clk, rst_aH              clock, asynchronous active-high reset
//   flush                    pipeline flush
//   icache_req_*             icache read request (valid/addr) and ready
//   dcache_req_*             dcache request (valid/type/addr/data) and ready
//   mem_req_*                request to memory (valid/type/addr/data, ready in)
//   mem_resp_*               read data returned by memory
//   icache_resp_*            read data forwarded to the icache
//   dcache_resp_*            read data forwarded to the dcache
// -----------------------------------------------------------------------------
module mem_ctrl_arbiter #(
    parameter int BLOCK_ADDR_WIDTH = 26,
    parameter int BLOCK_DATA_WIDTH = 512,
    parameter int STARVE_LIMIT     = 4
) (
    input  logic                        clk,
    input  logic                        rst_aH,
    input  logic                        flush,
    input  logic                        icache_req_valid,
    input  logic [BLOCK_ADDR_WIDTH-1:0] icache_req_block_addr,
    output logic                        icache_req_ready,
    input  logic                        dcache_req_valid,
    input  logic                        dcache_req_type,
    input  logic [BLOCK_ADDR_WIDTH-1:0] dcache_req_block_addr,
    input  logic [BLOCK_DATA_WIDTH-1:0] dcache_req_block_data,
    output logic                        dcache_req_ready,
    output logic                        mem_req_valid,
    output logic                        mem_req_type,
    output logic [BLOCK_ADDR_WIDTH-1:0] mem_req_block_addr,
    output logic [BLOCK_DATA_WIDTH-1:0] mem_req_block_data,
    input  logic                        mem_req_ready,
    input  logic                        mem_resp_valid,
    input  logic [BLOCK_DATA_WIDTH-1:0] mem_resp_block_data,
    output logic                        icache_resp_valid,
    output logic [BLOCK_DATA_WIDTH-1:0] icache_resp_block_data,
    output logic                        dcache_resp_valid,
    output logic [BLOCK_DATA_WIDTH-1:0] dcache_resp_block_data
);

    // The counter must hold the value STARVE_LIMIT itself.
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } state_t;

    state_t                      state;
    state_t                      state_next;
    logic                        owner;      // 0: icache, 1: dcache
    logic                        req_type;   // 0: read, 1: write
    logic [BLOCK_ADDR_WIDTH-1:0] req_addr;
    logic [BLOCK_DATA_WIDTH-1:0] req_data;
    logic [CNT_W-1:0]            starve_cnt;
    logic                        squash;
    logic                        grant_i;
    logic                        grant_d;
    logic                        starve_full;
    logic                        resp_fire;

    assign starve_full = (starve_cnt == STARVE_MAX);

    // Next-state and grant decision
    always_comb begin
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        case (state)
            IDLE: begin
                // icache wins unless the dcache is waiting and has been starved.
                if (icache_req_valid && !(dcache_req_valid && starve_full)) begin
                    grant_i = 1'b1;
                end else if (dcache_req_valid) begin
                    grant_d = 1'b1;
                end
                if (grant_i || grant_d) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                // Writes complete on the handshake; no response is expected.
                if (mem_req_ready) begin
                    state_next = req_type ? IDLE : WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (mem_resp_valid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and request capture
    always_ff @(posedge clk or posedge rst_aH) begin
        if (rst_aH) begin
            state      <= IDLE;
            owner      <= 1'b0;
            req_type   <= 1'b0;
            req_addr   <= '0;
            req_data   <= '0;
            starve_cnt <= '0;
            squash     <= 1'b0;
        end else begin
            state <= state_next;
            if (grant_i) begin
                owner    <= 1'b0;
                req_type <= 1'b0;
                req_addr <= icache_req_block_addr;
                req_data <= '0;
                squash   <= 1'b0;
                // Only grants that made the dcache wait count as starvation.
                if (dcache_req_valid && !starve_full) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end else if (grant_d) begin
                owner      <= 1'b1;
                req_type   <= dcache_req_type;
                req_addr   <= dcache_req_block_addr;
                req_data   <= dcache_req_block_data;
                squash     <= 1'b0;
                starve_cnt <= '0;
            end else if (flush && owner && (state != IDLE)) begin
                squash <= 1'b1;
            end
        end
    end

    // Outputs
    assign icache_req_ready = grant_i;
    assign dcache_req_ready = grant_d;

    assign mem_req_valid      = (state == ISSUE);
    assign mem_req_type       = (state == ISSUE) ? req_type : 1'b0;
    assign mem_req_block_addr = (state == ISSUE) ? req_addr : '0;
    assign mem_req_block_data = (state == ISSUE) ? req_data : '0;

    // A response arriving in any other state is dropped.
    assign resp_fire = (state == WAIT_RESP) && mem_resp_valid;

    // A flush landing in the response cycle itself squashes that response too.
    assign icache_resp_valid = resp_fire && !owner;
    assign dcache_resp_valid = resp_fire && owner && !squash && !flush;

    assign icache_resp_block_data = icache_resp_valid ? mem_resp_block_data : '0;
    assign dcache_resp_block_data = dcache_resp_valid ? mem_resp_block_data : '0;

endmodule
